lcd_ctrl: RTL and testbench
===========================

LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 The block SHALL have parameter SETUP_CYC, default 4: cycles RS/DATA are stable before EN rises.
REQ-002 The block SHALL have parameter PULSE_CYC, default 12: cycles EN is held high.
REQ-003 The block SHALL have parameter HOLD_CYC, default 2: cycles RS/DATA are held after EN falls.
REQ-004 The block SHALL have parameter EXEC_CYC, default 2000: execution wait for normal commands and data.
REQ-005 The block SHALL have parameter EXEC_LONG_CYC, default 82000: execution wait for clear and home commands.
REQ-006 The block SHALL have parameter POWERUP_CYC, default 2000000: power-on wait, used only under LCD_INIT_EN.
REQ-007 The block SHALL have one clock; reset is synchronous and active-high.
REQ-008 i_clk  in  1  clock; all state changes on its rising edge.
REQ-009 i_rst  in  1  reset, synchronous and active-high.
REQ-010 i_valid  in  1  request present.
REQ-011 i_rs  in  1  0 = command byte, 1 = data byte.
REQ-012 i_data  in  8  byte to write.
REQ-013 o_ready  out  1  block accepts a request this cycle.
REQ-014 o_lcd_on  out  1  LCD power/backlight enable.
REQ-015 o_lcd_en  out  1  HD44780 enable strobe.
REQ-016 o_lcd_rs  out  1  HD44780 register select.
REQ-017 o_lcd_rw  out  1  HD44780 read/write; this block only writes.
REQ-018 o_lcd_data  out  8  HD44780 data bus.

Function
REQ-019 The block SHALL use the states INIT_WAIT, INIT_CMD, IDLE, SETUP, PULSE, HOLD and EXEC.
REQ-020 o_ready SHALL be 1 exactly when the state is IDLE.
REQ-021 A transfer SHALL occur on a cycle where i_valid and o_ready are both 1; i_rs and i_data are latched on that edge.
REQ-022 Any i_valid while o_ready is 0 SHALL be ignored; the requester holds the request until it is accepted.
REQ-023 After a transfer the state SHALL be SETUP: o_lcd_rs and o_lcd_data take the latched values, o_lcd_en = 0, for SETUP_CYC cycles.
REQ-024 PULSE SHALL last PULSE_CYC cycles with o_lcd_en = 1.
REQ-025 HOLD SHALL last HOLD_CYC cycles with o_lcd_en = 0 and o_lcd_rs/o_lcd_data unchanged.
REQ-026 EXEC SHALL last EXEC_LONG_CYC cycles when the latched rs = 0 and data is in 0x01..0x03; otherwise EXEC_CYC cycles. After EXEC the state is IDLE.
REQ-027 From the transfer edge, o_ready SHALL return high after SETUP_CYC+PULSE_CYC+HOLD_CYC+EXEC(_LONG)_CYC cycles.
REQ-028 Any timing parameter set to 0 SHALL be treated as 1.
REQ-029 o_lcd_rs and o_lcd_data SHALL keep their last driven values while IDLE.
REQ-030 o_lcd_rw SHALL be constant 0.
REQ-031 o_lcd_on SHALL be 1 from the first cycle after reset deasserts.
REQ-032 The delay counter SHALL be sized to $clog2 of the largest parameter plus 1 bit, and SHALL never wrap.

Reset
REQ-033 When i_rst is 1 at a clock edge, the following SHALL take effect on the next cycle: o_lcd_en=0, o_lcd_rs=0, o_lcd_data=0x00, o_lcd_on=0, counter=0.
REQ-034 On reset the state SHALL become INIT_WAIT when LCD_INIT_EN is defined, otherwise IDLE.
REQ-035 Reset asserted mid-transfer SHALL abort the transfer, including dropping EN within one cycle; the latched byte is discarded.

Configuration
REQ-036 When macro LCD_INIT_EN is defined, the block SHALL run a power-on sequence:
- INIT_WAIT for POWERUP_CYC cycles;
- then INIT_CMD issues 0x38, 0x0C, 0x01, 0x06 (rs = 0) in that order, each through SETUP/PULSE/HOLD/EXEC;
- then IDLE.
- o_ready is 0 throughout.
REQ-037 When LCD_INIT_EN is undefined, INIT_WAIT and INIT_CMD SHALL not be synthesized, and o_ready SHALL be 1 on the first cycle after reset.

Structure
REQ-038 rv32i_pkg SHALL hold the lcd_state_e enum and the init command constants LCD_CMD_FUNC_SET=0x38, LCD_CMD_DISP_ON=0x0C, LCD_CMD_CLEAR=0x01 and LCD_CMD_ENTRY=0x06.
REQ-039 The delay SHALL be one sub-module lcd_timer: load a cycle count, assert done on its final cycle.

Verification (SETUP=2, PULSE=3, HOLD=1, EXEC=5, EXEC_LONG=20, POWERUP=10)
REQ-040 Bench SHALL cover: no macro, reset then valid, rs=1, data=0x41 -> EN high for exactly 3 cycles starting 2 cycles after the transfer edge; RS=1 and DATA=0x41 stable from 2 cycles before EN rises to 1 cycle after it falls; o_ready low for 11 cycles.
REQ-041 Bench SHALL cover: rs=0, data=0x01 -> o_ready low for 26 cycles; rs=0, data=0x04 -> 11 cycles.
REQ-042 Bench SHALL cover: second valid asserted during PULSE and held -> accepted only on the first IDLE cycle; exactly two EN pulses observed.
REQ-043 Bench SHALL cover: i_rst during PULSE -> o_lcd_en=0 and o_lcd_data=0x00 the next cycle; o_ready=1 the cycle after reset deasserts.
REQ-044 Bench SHALL cover: LCD_INIT_EN defined -> first EN rises after 10+2 cycles; bytes 0x38, 0x0C, 0x01, 0x06 appear in order; o_ready rises only after the final EXEC, and valid inputs are ignored until then.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared types and constants for the HD44780 write controller: FSM state encoding,
// power-on command bytes and parameter-clamping helpers.
package rv32i_pkg;

  typedef enum logic [2:0] {
    INIT_WAIT = 3'd0,
    INIT_CMD  = 3'd1,
    IDLE      = 3'd2,
    SETUP     = 3'd3,
    PULSE     = 3'd4,
    HOLD      = 3'd5,
    EXEC      = 3'd6
  } lcd_state_e;

  localparam logic [7:0] LCD_CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_CMD_ENTRY    = 8'h06;
  localparam logic [2:0] LCD_INIT_LEN     = 3'd4;

  // A zero-length phase would never raise done, so every timing value is at least 1.
  function automatic int cyc_min1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int cyc_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] c;
    case (idx)
      2'd0:    c = LCD_CMD_FUNC_SET;
      2'd1:    c = LCD_CMD_DISP_ON;
      2'd2:    c = LCD_CMD_CLEAR;
      2'd3:    c = LCD_CMD_ENTRY;
      default: c = LCD_CMD_FUNC_SET;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Phase delay counter: load a length, done is high on the last cycle of that length.
// Counts up from zero and saturates, so it never wraps while the FSM sits in IDLE.
module lcd_timer #(
  parameter int            CW      = 8,
  parameter logic [CW-1:0] RST_LEN = {{(CW-1){1'b0}}, 1'b1}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] len,
  output logic          done
);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] len_r;

  // Cycle counter and captured phase length.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
      len_r <= RST_LEN;
    end else if (load) begin
      cnt_r <= {CW{1'b0}};
      len_r <= len;
    end else if (cnt_r != {CW{1'b1}}) begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign done = (cnt_r == (len_r - {{(CW-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write-only controller: accepts one byte per valid/ready handshake and strobes it
// onto the LCD bus. Define LCD_INIT_EN to add the power-on wait and init command sequence.
module lcd_ctrl
  import rv32i_pkg::*;
#(
  parameter int SETUP_CYC     = 4,
  parameter int PULSE_CYC     = 12,
  parameter int HOLD_CYC      = 2,
  parameter int EXEC_CYC      = 2000,
  parameter int EXEC_LONG_CYC = 82000,
  parameter int POWERUP_CYC   = 2000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_lcd_on,
  output logic       o_lcd_en,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic [7:0] o_lcd_data
);

  localparam int SETUP_N     = cyc_min1(SETUP_CYC);
  localparam int PULSE_N     = cyc_min1(PULSE_CYC);
  localparam int HOLD_N      = cyc_min1(HOLD_CYC);
  localparam int EXEC_N      = cyc_min1(EXEC_CYC);
  localparam int EXEC_LONG_N = cyc_min1(EXEC_LONG_CYC);
  localparam int POWERUP_N   = cyc_min1(POWERUP_CYC);
  localparam int MAX_N = cyc_max(cyc_max(cyc_max(SETUP_N, PULSE_N), cyc_max(HOLD_N, EXEC_N)),
                                 cyc_max(EXEC_LONG_N, POWERUP_N));
  localparam int CW = $clog2(MAX_N) + 1;

`ifdef LCD_INIT_EN
  localparam lcd_state_e    RST_STATE = INIT_WAIT;
  localparam logic          RST_READY = 1'b0;
  localparam logic [CW-1:0] RST_LEN   = CW'(POWERUP_N);
`else
  localparam lcd_state_e    RST_STATE = IDLE;
  localparam logic          RST_READY = 1'b1;
  localparam logic [CW-1:0] RST_LEN   = CW'(1);
`endif

  lcd_state_e    state_r, next_s;
  logic          load_s, done_s, latch_s, latch_rs_s, long_s;
  logic [CW-1:0] len_s;
  logic [7:0]    latch_data_s;
  logic          lcd_en_r, lcd_rs_r, lcd_on_r, ready_r;
  logic [7:0]    lcd_data_r;
`ifdef LCD_INIT_EN
  logic          issue_s;
  logic [2:0]    init_idx_r;
`endif

  lcd_timer #(.CW(CW), .RST_LEN(RST_LEN)) u_timer (
    .clk  (i_clk),
    .rst  (i_rst),
    .load (load_s),
    .len  (len_s),
    .done (done_s)
  );

  // Clear and return-home are the slow HD44780 commands.
  assign long_s = !lcd_rs_r && (lcd_data_r >= 8'h01) && (lcd_data_r <= 8'h03);

  // Next-state, timer reload and bus-latch decode.
  always_comb begin
    next_s       = state_r;
    load_s       = 1'b0;
    len_s        = CW'(SETUP_N);
    latch_s      = 1'b0;
    latch_rs_s   = i_rs;
    latch_data_s = i_data;
`ifdef LCD_INIT_EN
    issue_s      = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (i_valid) begin
          next_s  = SETUP;
          load_s  = 1'b1;
          latch_s = 1'b1;
        end else begin
          next_s = IDLE;
        end
      end
      SETUP: begin
        if (done_s) begin
          next_s = PULSE;
          load_s = 1'b1;
          len_s  = CW'(PULSE_N);
        end else begin
          next_s = SETUP;
        end
      end
      PULSE: begin
        if (done_s) begin
          next_s = HOLD;
          load_s = 1'b1;
          len_s  = CW'(HOLD_N);
        end else begin
          next_s = PULSE;
        end
      end
      HOLD: begin
        if (done_s) begin
          next_s = EXEC;
          load_s = 1'b1;
          len_s  = long_s ? CW'(EXEC_LONG_N) : CW'(EXEC_N);
        end else begin
          next_s = HOLD;
        end
      end
      EXEC: begin
        if (done_s) begin
`ifdef LCD_INIT_EN
          next_s = (init_idx_r != LCD_INIT_LEN) ? INIT_CMD : IDLE;
`else
          next_s = IDLE;
`endif
        end else begin
          next_s = EXEC;
        end
      end
`ifdef LCD_INIT_EN
      INIT_WAIT: begin
        if (done_s) begin
          next_s = INIT_CMD;
        end else begin
          next_s = INIT_WAIT;
        end
      end
      INIT_CMD: begin
        next_s       = SETUP;
        load_s       = 1'b1;
        latch_s      = 1'b1;
        latch_rs_s   = 1'b0;
        latch_data_s = init_cmd(init_idx_r[1:0]);
        issue_s      = 1'b1;
      end
`endif
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  // State register and registered LCD bus outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r    <= RST_STATE;
      lcd_en_r   <= 1'b0;
      lcd_rs_r   <= 1'b0;
      lcd_data_r <= 8'h00;
      lcd_on_r   <= 1'b0;
      ready_r    <= RST_READY;
`ifdef LCD_INIT_EN
      init_idx_r <= 3'd0;
`endif
    end else begin
      state_r  <= next_s;
      lcd_en_r <= (next_s == PULSE);
      ready_r  <= (next_s == IDLE);
      lcd_on_r <= 1'b1;
      if (latch_s) begin
        lcd_rs_r   <= latch_rs_s;
        lcd_data_r <= latch_data_s;
      end
`ifdef LCD_INIT_EN
      if (issue_s) begin
        init_idx_r <= init_idx_r + 3'd1;
      end
`endif
    end
  end

  assign o_ready    = ready_r;
  assign o_lcd_on   = lcd_on_r;
  assign o_lcd_en   = lcd_en_r;
  assign o_lcd_rs   = lcd_rs_r;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_data = lcd_data_r;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: the driver queues the expected strobe per request, and a
// negedge monitor measures each busy window and compares it against the queue head.
module tb_lcd_ctrl;

  localparam int S = 2, P = 3, H = 1, E = 5, EL = 20, PU = 10;
`ifdef LCD_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst, i_valid, i_rs;
  logic [7:0] i_data;
  logic       o_ready, o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw;
  logic [7:0] o_lcd_data;

  lcd_ctrl #(.SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .EXEC_CYC(E),
             .EXEC_LONG_CYC(EL), .POWERUP_CYC(PU)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_rs(i_rs), .i_data(i_data),
    .o_ready(o_ready), .o_lcd_on(o_lcd_on), .o_lcd_en(o_lcd_en), .o_lcd_rs(o_lcd_rs),
    .o_lcd_rw(o_lcd_rw), .o_lcd_data(o_lcd_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         busy;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, failures = 0, pushed = 0, rises_total = 0;
  bit   mon_en = 1'b0, in_win = 1'b0, prev_en, seen_en;
  int   gap_cnt = 0, busy, setup, en_w, pulses, bad;
  exp_t cur;

  function automatic void check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  // Monitor: one busy window (o_ready low) per accepted request.
  always @(negedge i_clk) begin
    if (!mon_en) begin
      in_win  = 1'b0;
      gap_cnt = 0;
    end else if (!o_ready) begin
      if (!in_win) begin
        in_win = 1'b1; busy = 0; setup = 0; en_w = 0; pulses = 0; bad = 0;
        prev_en = 1'b0; seen_en = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_transfer", 1, 0);
          cur.rs = 1'b0; cur.data = 8'h00; cur.busy = 0; cur.gap = -1;
        end else begin
          cur = exp_q.pop_front();
        end
        if (cur.gap >= 0) check("idle_gap", gap_cnt, cur.gap);
      end
      busy++;
      if (o_lcd_en) begin
        en_w++;
        seen_en = 1'b1;
        if (!prev_en) begin pulses++; rises_total++; end
      end else if (!seen_en) begin
        setup++;
      end
      if (o_lcd_rs !== cur.rs || o_lcd_data !== cur.data) bad++;
      prev_en = o_lcd_en;
    end else begin
      if (in_win) begin
        check("busy_cycles", busy, cur.busy);
        check("setup_cycles", setup, S);
        check("en_width", en_w, P);
        check("en_pulses", pulses, 1);
        check("rs_data_unstable", bad, 0);
        in_win  = 1'b0;
        gap_cnt = 1;
      end else begin
        gap_cnt++;
      end
    end
  end

  // Called at a negedge; holds the request until accepted, returns at a negedge.
  task automatic send(input logic rs, input logic [7:0] d, input int busy_exp,
                      input int gap_exp, input bit push);
    int   t;
    exp_t e;
    if (push) begin
      e.rs = rs; e.data = d; e.busy = busy_exp; e.gap = gap_exp;
      exp_q.push_back(e);
      pushed++;
    end
    i_valid = 1'b1; i_rs = rs; i_data = d;
    t = 0;
    while (!o_ready && t < 200) begin
      @(negedge i_clk);
      t++;
    end
    check("accept_in_time", int'(t < 200), 1);
    if (o_ready) @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_en();
    int t;
    t = 0;
    while (!o_lcd_en && t < 50) begin
      @(negedge i_clk);
      t++;
    end
    check("en_seen", int'(t < 50), 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge i_clk); #1;
    while ((exp_q.size() != 0 || in_win || !o_ready) && t < 500) begin
      @(negedge i_clk); #1;
      t++;
    end
    check("drain", int'(t < 500), 1);
  endtask

  exp_t vec[8] = '{
    '{1'b1, 8'h41, 11, -1}, '{1'b0, 8'h01, 26, -1}, '{1'b0, 8'h04, 11, -1},
    '{1'b0, 8'h02, 26, -1}, '{1'b0, 8'h03, 26, -1}, '{1'b0, 8'h00, 11, -1},
    '{1'b1, 8'h01, 11, -1}, '{1'b1, 8'hFF, 11, -1}
  };

`ifdef LCD_INIT_EN
  logic [7:0] init_exp[4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
  logic [7:0] got[4];
  int         cyc, nrise, first;
  bit         prev;
`endif

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_rs = 1'b0; i_data = 8'h00;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_en", o_lcd_en, 0);
    check("rst_rs", o_lcd_rs, 0);
    check("rst_data", o_lcd_data, 0);
    check("rst_on", o_lcd_on, 0);
    check("rst_rw", o_lcd_rw, 0);
    check("rst_ready", o_ready, INIT_EN ? 0 : 1);
    @(negedge i_clk); i_rst = 1'b0;
    @(posedge i_clk); #1;
    check("on_after_rst", o_lcd_on, 1);

`ifdef LCD_INIT_EN
    // Request held through the whole init sequence must be ignored.
    i_valid = 1'b1; i_rs = 1'b1; i_data = 8'hEE;
    cyc = 0; nrise = 0; first = -1; prev = 1'b0;
    @(negedge i_clk);
    while (!o_ready && cyc < 300) begin
      if (o_lcd_en && !prev) begin
        if (nrise == 0) first = cyc;
        if (nrise < 4) got[nrise] = o_lcd_data;
        nrise++;
      end
      prev = o_lcd_en;
      cyc++;
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    check("init_first_en", first, 12);
    check("init_ready_cycle", cyc, 72);
    check("init_pulses", nrise, 4);
    for (int i = 0; i < 4; i++) check("init_byte", got[i], init_exp[i]);
`endif

    @(negedge i_clk);
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) send(vec[i].rs, vec[i].data, vec[i].busy, -1, 1'b1);

    // Back-to-back: second request raised during PULSE, accepted on the first IDLE cycle.
    send(1'b1, 8'h41, 11, -1, 1'b1);
    wait_en();
    send(1'b1, 8'h42, 11, 1, 1'b1);
    drain();

    // Reset while EN is high aborts the strobe on the next edge.
    @(negedge i_clk);
    mon_en = 1'b0;
    send(1'b1, 8'h55, 0, -1, 1'b0);
    wait_en();
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    check("abort_en", o_lcd_en, 0);
    check("abort_data", o_lcd_data, 0);
    check("abort_rs", o_lcd_rs, 0);
    check("abort_on", o_lcd_on, 0);
    @(negedge i_clk); i_rst = 1'b0;
    @(posedge i_clk); #1;
`ifndef LCD_INIT_EN
    check("ready_after_rst", o_ready, 1);
`endif
    check("abort_en_stays_low", o_lcd_en, 0);

    @(negedge i_clk);
    mon_en = 1'b1;
    send(1'b0, 8'h80, 11, -1, 1'b1);
    drain();
    check("total_pulses", rises_total, pushed);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
